// File: rtl/alu_seq.sv
// alu_seq: registered ALU with persistent zero/carry flags, carry-chained ops, shifts and a WIDTH-cycle shift-add multiplier (in_valid/in_ready/a/b/op in; out/zero/carry/out_valid out)
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             carry
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_SBC = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_out;
  logic               r_valid;
  logic               r_zero;
  logic               r_carry;
  logic               w_inv_b;
  logic               w_cin;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_accept;
  logic               w_last;
  assign in_ready  = r_state == S_IDLE;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = r_state == S_BUSY && r_cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    w_inv_b = op == OP_SUB || op == OP_SBC;
    w_cin = op == OP_SUB ? 1'b1 : (op == OP_ADC || op == OP_SBC) ? r_carry : 1'b0;
    w_b = w_inv_b ? ~b : b;
    w_sum = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    w_res = op == OP_NAND ? ~(a & b) :
            op == OP_SHL  ? {a[WIDTH-2:0], 1'b0} :
            op == OP_SHR  ? {1'b0, a[WIDTH-1:1]} : w_sum[WIDTH-1:0];
    w_cout = op == OP_NAND ? 1'b0 :
             op == OP_SHL  ? a[WIDTH-1] :
             op == OP_SHR  ? a[0] : w_sum[WIDTH];
    w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept && op == OP_MUL) begin
          r_state  <= S_BUSY;
          r_cnt    <= '0;
          r_prod   <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, a};
          r_mplier <= b;
        end else if (w_accept) begin
          r_out   <= w_res;
          r_zero  <= w_res == '0;
          r_carry <= w_cout;
          r_valid <= 1'b1;
        end
      end else begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_state <= S_IDLE;
          r_out   <= w_prod_nxt[WIDTH-1:0];
          r_zero  <= w_prod_nxt[WIDTH-1:0] == '0;
          r_carry <= |w_prod_nxt[2*WIDTH-1:WIDTH];
          r_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         zero;
  logic         carry;
  int n_chk = 0;
  int n_fail = 0;
  int unsigned m_out = 0;
  int unsigned m_pend_out = 0;
  bit m_zero = 0, m_carry = 0, m_valid = 0, m_ready = 1, m_pend_c = 0, m_init = 0;
  int m_left = 0;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out(out), .out_valid(out_valid), .zero(zero), .carry(carry)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    int unsigned ua, ub, p;
    ua = a;
    ub = b;
    if (!rst_n) begin
      m_out = 0; m_zero = 0; m_carry = 0; m_valid = 0; m_ready = 1; m_left = 0; m_init = 1;
    end else begin
      m_valid = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out = m_pend_out; m_carry = m_pend_c; m_zero = m_out == 0; m_valid = 1; m_ready = 1;
        end
      end else if (in_valid) begin
        case (op)
          3'd0: begin p = ua + ub; m_out = p % 256; m_carry = p > 255; end
          3'd1: begin m_carry = ua >= ub; m_out = (ua - ub) & 255; end
          3'd2: begin m_out = ~(ua & ub) & 255; m_carry = 0; end
          3'd3: begin p = ua + ub + m_carry; m_out = p % 256; m_carry = p > 255; end
          3'd4: begin p = ua + m_carry; m_out = (p - ub - 1) & 255; m_carry = p >= ub + 1; end
          3'd5: begin m_out = (ua * 2) & 255; m_carry = ua >= 128; end
          3'd6: begin m_out = ua / 2; m_carry = ua % 2; end
          default: begin p = ua * ub; m_pend_out = p % 256; m_pend_c = p > 255; m_left = W; m_ready = 0; end
        endcase
        if (op != 3'd7) begin m_zero = m_out == 0; m_valid = 1; end
      end
    end
  end
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_out", int'(out), int'(m_out));
      chk("model_zero", int'(zero), int'(m_zero));
      chk("model_carry", int'(carry), int'(m_carry));
      chk("model_out_valid", int'(out_valid), int'(m_valid));
      chk("model_in_ready", int'(in_ready), int'(m_ready));
    end
  end
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop);
    in_valid = 1'b1; a = ia; b = ib; op = iop;
    for (int t = 0; t < 40 && !in_ready; t++) @(negedge clk);
    if (!in_ready) chk("issue_in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic expect_res(input string name, input int eo, input int ez, input int ec);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_out"}, int'(out), eo);
    chk({name, "_zero"}, int'(zero), ez);
    chk({name, "_carry"}, int'(carry), ec);
  endtask
  task automatic wait_valid(output int n, output int low);
    n = 0;
    low = 0;
    while (!out_valid && n < 30) begin
      if (!in_ready) low++;
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("wait_out_valid_timeout", 0, 1);
  endtask
  initial begin
    int n, low;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_out", int'(out), 0);
    chk("reset_flags", int'({zero, carry, out_valid}), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    issue(3, 5, 3'd1); expect_res("sub_3_5", 254, 0, 0);
    issue(3, 5, 3'd0); expect_res("add_3_5", 8, 0, 0);
    issue(3, 5, 3'd2); expect_res("nand_3_5", 254, 0, 0);
    issue(3, 3, 3'd1); expect_res("sub_3_3", 0, 1, 1);
    issue(3, 2, 3'd1); expect_res("sub_3_2", 1, 0, 1);
    issue(255, 1, 3'd0); expect_res("add_255_1", 0, 1, 1);
    issue(0, 0, 3'd3); expect_res("adc_0_0_c1", 1, 0, 0);
    issue(5, 5, 3'd4); expect_res("sbc_5_5_c0", 255, 0, 0);
    issue(255, 255, 3'd0); expect_res("add_max_max", 254, 0, 1);
    issue(0, 0, 3'd1); expect_res("sub_0_0", 0, 1, 1);
    issue(8'h81, 0, 3'd5); expect_res("shl_81", 2, 0, 1);
    issue(8'h01, 0, 3'd6); expect_res("shr_01", 0, 1, 1);
    issue(13, 11, 3'd7);
    wait_valid(n, low);
    chk("mul_latency", n + 1, W + 1);
    chk("mul_ready_low_cycles", low, W);
    expect_res("mul_13_11", 143, 0, 0);
    issue(20, 20, 3'd7);
    in_valid = 1'b1; a = 1; b = 1; op = 3'd0;
    wait_valid(n, low);
    expect_res("mul_20_20", 144, 0, 1);
    chk("mul_20_20_ready_after", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    expect_res("held_add_after_mul", 2, 0, 0);
    issue(77, 0, 3'd7);
    wait_valid(n, low);
    expect_res("mul_by_0", 0, 1, 0);
    issue(13, 11, 3'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midmul_reset_out", int'(out), 0);
    chk("midmul_reset_flags", int'({zero, carry, out_valid}), 0);
    chk("midmul_reset_in_ready", int'(in_ready), 1);
    low = 0;
    repeat (12) begin
      if (out_valid) low++;
      @(negedge clk);
    end
    chk("midmul_no_out_valid", low, 0);
    issue(1, 1, 3'd0); expect_res("add_1_1_after_reset", 2, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = sel == 0 ? 8'd0 : sel == 1 ? 8'd255 : 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      b = sel == 0 ? 8'd0 : sel == 1 ? 8'd255 : 8'($urandom_range(0, 255));
      op = 3'($urandom_range(0, 7));
      in_valid = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 199) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds the following over the combinational ALU:
  - configurable width;
  - persistent flag register;
  - carry-chained ops (ADC/SBC);
  - shifts;
  - a multi-cycle shift-add multiplier behind a valid/ready handshake.
- Sits between the register file read ports and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of the internal multiply iteration counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  ADD=0, SUB=1, NAND=2, ADC=3, SBC=4, SHL=5, SHR=6, MUL=7
- out  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse when out/flags are updated
- zero  out  1  registered zero flag
- carry  out  1  registered carry flag

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n.
  - With rst_n=0 at a rising edge, the block enters state IDLE and sets out=0, out_valid=0, zero=0, carry=0, in_ready=1 (asserted from the next cycle), and clears the counter.
- Handshake:
  - An op is accepted on a rising edge where in_valid & in_ready.
  - a, b, op and the current carry flag are sampled at that edge.
- States: IDLE, BUSY.
  - IDLE: in_ready=1.
  - Non-MUL op accepted: stay in IDLE. Next cycle: out_valid=1 with out/zero/carry updated (latency 1). Back-to-back ops accepted every cycle.
  - MUL accepted: go to BUSY. in_ready=0 throughout BUSY. BUSY runs exactly WIDTH cycles, one shift-add iteration each.
  - Last BUSY cycle: register the result, return to IDLE, pulse out_valid the following cycle. MUL latency is WIDTH+1 cycles from acceptance to out_valid. A new op may be accepted on the edge where out_valid rises.
- Arithmetic: all unsigned, WIDTH bits; carry is bit WIDTH of the extended result.
  - ADD: out=a+b; carry=carry-out.
  - SUB: out=a-b, computed as a+~b+1; carry=1 when no borrow (a>=b).
  - ADC: out=a+b+C; carry=carry-out.
  - SBC: out=a+~b+C; carry=1 when no borrow. C is the carry flag sampled at acceptance.
  - NAND: out=~(a&b); carry=0.
  - SHL: out=a<<1; carry=a[WIDTH-1].
  - SHR: out=a>>1, logical; carry=a[0].
  - MUL: out=low WIDTH bits of a*b; carry=1 if the high WIDTH bits of the 2*WIDTH product are nonzero.
- Flags:
  - zero = (out==0) for every op.
  - Flags change only in a cycle where out_valid=1; otherwise they hold.
  - out holds its last value between results.
- Boundaries:
  - Max+max ADD wraps with carry=1.
  - 0-0 SUB gives zero=1, carry=1.
  - MUL by 0 gives zero=1, carry=0.
  - in_valid while BUSY is ignored; the source must hold it until in_ready.
- Reset mid-MUL: aborts; the result is discarded; no out_valid; the module returns to IDLE with all outputs at reset values.

Test Plan:
- WIDTH=8. a=3, b=5, SUB -> next cycle out=254, zero=0, carry=0. Then ADD -> out=8, carry=0. Then NAND -> out=254, carry=0.
- SUB with a=3, b=3 -> out=0, zero=1, carry=1. Then a=3, b=2, SUB -> out=1, zero=0, carry=1.
- ADD 255+1 -> out=0, zero=1, carry=1. Next cycle, ADC a=0, b=0 -> out=1, carry=0. Then SBC a=5, b=5 with carry=0 -> out=255, carry=0.
- SHL a=0x81 -> out=0x02, carry=1. Then SHR a=0x01 -> out=0, zero=1, carry=1.
- MUL 13*11 -> in_ready low for 8 cycles, out_valid 9 cycles after acceptance, out=143, carry=0. MUL 20*20 -> out=144, carry=1. in_valid held during BUSY is not accepted until in_ready returns.
- Assert rst_n=0 for one edge 3 cycles into a MUL -> no out_valid; out=0, zero=0, carry=0, in_ready=1 next cycle. A following ADD 1+1 -> out=2 with latency 1.
